// File: rtl/seven_seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seven_seg_pkg : shared constants, FSM state type and hex-to-segment table   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package seven_seg_pkg;

    // Segment vectors are indexed [0:6] = a..g, active-low.
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam logic [0:6] SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_hold_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_display_hold_driver_if : packed-hex word in, display pins and done out  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface hex_display_hold_driver_if;

    logic [15:0] hex_in;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        done;

    // master = the client bench supplying words; slave = the display driver
    modport master (
        output hex_in,
        input  seg,
        input  an,
        input  done
    );

    modport slave (
        input  hex_in,
        output seg,
        output an,
        output done
    );

endinterface
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_to_7seg : combinational 4-bit hex to active-low a..g segment decoder    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hex_to_7seg
    import seven_seg_pkg::*;
(
    input  wire logic [3:0] nibble,
    output logic      [0:6] seg
);

    assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/hex_display_hold_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_display_hold_driver : holds a captured 16-bit word for a fixed period,  |
// | scans it onto a 4-digit 7-seg display and pulses done per period. Rev 1.0   |
// +----------------------------------------------------------------------------+
module hex_display_hold_driver
    import seven_seg_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SCAN_CYCLES = 100_000
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    hex_display_hold_driver_if.slave  bus
);

    localparam int c_hold_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_scan_w = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_CYCLES - 1);

    generate
        if (HOLD_CYCLES < 2) begin : g_bad_hold
            $error("HOLD_CYCLES must be >= 2");
        end
        if (SCAN_CYCLES < 1) begin : g_bad_scan
            $error("SCAN_CYCLES must be >= 1");
        end
    endgenerate

    state_t              r_state;
    logic [15:0]         r_shadow;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [1:0]          r_digit;
    logic [0:6]          r_seg;
    logic [3:0]          r_an;
    logic                r_done;

    logic [3:0]          w_nibble;
    logic [0:6]          w_seg;

    // One decoder shared by all digits: pick the nibble for the digit being lit.
    assign w_nibble = r_shadow[{r_digit, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .nibble (w_nibble),
        .seg    (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_shadow   <= '0;
            r_hold_cnt <= '0;
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_seg      <= SEG_BLANK;
            r_an       <= AN_OFF;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_shadow <= bus.hex_in;
                    r_state  <= ST_SHOW;
                    r_done   <= 1'b0;
                    r_seg    <= SEG_BLANK;
                    r_an     <= AN_OFF;
                end

                ST_SHOW: begin
                    // an and seg share one register stage so the pins never disagree.
                    r_an  <= ~(4'b0001 << r_digit);
                    r_seg <= w_seg;

                    if (r_hold_cnt == c_hold_last) begin
                        r_hold_cnt <= '0;
                        r_shadow   <= bus.hex_in;
                        r_done     <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                        r_done     <= 1'b0;
                    end

                    // Scan is free-running; a new word does not restart it.
                    if (r_scan_cnt == c_scan_last) begin
                        r_scan_cnt <= '0;
                        r_digit    <= r_digit + 2'd1;
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_hold_driver.sv
`default_nettype none
// Scoreboarded bench: a cycle-count reference model predicts the pins after every
// edge; a monitor on the falling edge pops and compares.
module tb_hex_display_hold_driver;

    localparam int H = 20;
    localparam int S = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       done;
    } obs_t;

    localparam obs_t BLANK = '{seg: 7'b1111111, an: 4'b1111, done: 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_display_hold_driver_if bus ();

    hex_display_hold_driver #(
        .HOLD_CYCLES (H),
        .SCAN_CYCLES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_ref [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    obs_t exp_q[$];
    bit   started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: t = edges since reset release (edge 0 is the capture edge).
    // Outputs after edge t show digit ((t-1)/S)%4 of the word held before that edge;
    // done follows every edge where t is a non-zero multiple of H, which also captures.
    int          m_t = -1;
    logic [15:0] m_word = '0;
    always @(posedge clk) begin
        obs_t e;
        int   d;
        int   nib;
        started = 1'b1;
        if (!rst_n) begin
            m_t = -1;
            e   = BLANK;
        end else begin
            m_t = m_t + 1;
            if (m_t == 0) begin
                m_word = bus.hex_in;
                e      = BLANK;
            end else begin
                d      = ((m_t - 1) / S) % 4;
                nib    = (int'(m_word) >> (4 * d)) & 15;
                e.seg  = seg_ref[nib];
                e.an   = 4'b1111 & ~(4'b0001 << d);
                e.done = ((m_t % H) == 0);
                if (e.done) m_word = bus.hex_in;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: a pending prediction is overridden by an asynchronous reset.
    always @(negedge clk) begin
        obs_t e;
        if (started) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (!rst_n) e = BLANK;
                check("seg", 32'(bus.seg), 32'(e.seg));
                check("an", 32'(bus.an), 32'(e.an));
                check("done", 32'(bus.done), 32'(e.done));
            end
        end
    end

    task automatic wait_done(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 200);
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no done within %0d cycles", name, n);
        end
    endtask

    initial begin
        int          n;
        logic [15:0] cnt;
        logic [15:0] pats [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

        bus.hex_in = 16'h1234;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        wait_done("first_done", n);
        check("first_done_latency", n, H + 1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 0);
        repeat (6) @(negedge clk);

        // Asynchronous reset mid-cycle must blank the pins before the next edge.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_seg", 32'(bus.seg), 32'h7F);
        check("async_an", 32'(bus.an), 32'hF);
        check("async_done", 32'(bus.done), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_done("relaunch_done", n);
        check("relaunch_latency", n, H + 1);

        // Word changed mid-period stays invisible until the next done.
        repeat (5) @(negedge clk);
        bus.hex_in = 16'hABCD;
        wait_done("hold_done", n);
        check("hold_period", n, H - 5);
        repeat (H - 2) @(negedge clk);

        foreach (pats[i]) begin
            wait_done("decode_done", n);
            bus.hex_in = pats[i];
        end
        wait_done("decode_last", n);
        repeat (H - 2) @(negedge clk);

        // Random churn on hex_in between done pulses.
        repeat (6 * H) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) bus.hex_in = 16'($urandom);
        end

        // Reset roughly halfway through a period: the old terminal never fires.
        wait_done("mid_sync", n);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_done("mid_reset_done", n);
        check("mid_reset_latency", n, H + 1);

        // Counting client: advances its word on every done.
        cnt = 16'($urandom);
        bus.hex_in = cnt;
        for (int p = 0; p < 10; p++) begin
            wait_done("client_done", n);
            check("client_period", n, H);
            cnt = cnt + 16'd1;
            bus.hex_in = cnt;
        end
        repeat (H + 2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
